cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 block for the multicycle MIPS CPU. It is the producer side of the exception/return path that the next-PC logic consumes.
- Samples hardware interrupts and raises an interrupt request at instruction boundaries.
- On exception entry, captures the return address into EPC and sets EXL.
- On eret, clears EXL and presents EPC to the next-PC selector; the handler vector 0x0000_4180 is selected there.
- Also serves mfc0/mtc0 register reads and writes.

Parameters:
- PRID_VAL, 32'h0000_3130, constant value returned by PRId (reg 15).
- IRQ_W, 6, number of hardware interrupt lines (mapped to IP/IM bits starting at bit 10).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  address execution resumes at if the interrupt is taken (the next-instruction PC at the boundary).
- addr  in  5  CP0 register number for read/write.
- din  in  32  mtc0 write data.
- we  in  1  mtc0 write strobe, one cycle.
- exl_set  in  1  exception-entry strobe from control FSM, one cycle.
- exl_clr  in  1  eret strobe from control FSM, one cycle.
- hwint  in  IRQ_W  level-sensitive device interrupt lines.
- intreq  out  1  interrupt pending and enabled; control FSM samples it at instruction boundary.
- epc  out  32  current EPC; drives the next-PC EPC input.
- dout  out  32  mfc0 read data.

Behaviour:
- Register map:
  - 12 = SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - 13 = Cause: IP[15:10], ExcCode[6:2]; all other bits read 0.
  - 14 = EPC.
  - 15 = PRId.
  - Any other addr reads 32'h0 and ignores writes.
- Reset (rst=1 at clk edge): IM=0, EXL=0, IE=0, IP=0, ExcCode=0, EPC=0. Resulting outputs: intreq=0, epc=0, dout=0 for all addrs except 15 (PRID_VAL). Reset overrides every strobe in the same cycle, including mid-handler.
- IP capture: IP <= hwint every cycle. One cycle of latency from hwint to IP; IP is read-only (mtc0 to 13 leaves IP unchanged).
- intreq = |(IP & IM) & IE & ~EXL. It is combinational from registered state, so it rises one cycle after hwint.
- mtc0 (we=1):
  - addr 12: IM <= din[15:10], EXL <= din[1], IE <= din[0].
  - addr 14: EPC <= {din[31:2],2'b00}.
  - addr 13/15: no effect.
- Exception entry (exl_set=1): EPC <= {pc[31:2],2'b00}, EXL <= 1, ExcCode <= 5'd0 (interrupt). intreq falls in the next cycle.
- eret (exl_clr=1): EXL <= 0; EPC is unchanged. intreq may reassert the following cycle if IP&IM is still nonzero.
- Priority within one cycle is rst > exl_set > we > exl_clr, applied per field:
  - exl_set with exl_clr: EXL=1.
  - exl_set with we to 14: EPC takes pc.
  - exl_set with we to 12: IM/IE take din, EXL=1.
  - we to 12 with exl_clr: EXL takes din[1].
- Output timing:
  - dout is combinational on addr and reflects state before the current edge; a write followed by a read in the next cycle returns the new value.
  - epc is a direct register output, so the updated EPC is visible the cycle after exl_set.
- Nested interrupts: none while EXL=1. intreq stays 0 regardless of hwint until eret or an SR write clears EXL.

Test Plan:
- Reset then read 12/13/14/15 -> 0, 0, 0, 32'h0000_3130; intreq=0 with hwint=6'b111111.
- mtc0 SR=32'h0000_0401 (IM[0]=1, IE=1), assert hwint[0] at cycle N -> IP[10] set and intreq=1 at cycle N+1; hwint[1] alone leaves intreq=0.
- With intreq=1, pc=32'h0000_3010, pulse exl_set -> next cycle: epc=32'h0000_3010, SR read = 32'h0000_0403, intreq=0 even with hwint held.
- Pulse exl_clr with hwint still high -> EXL=0, intreq=1 one cycle later, epc still 32'h0000_3010.
- Same cycle: exl_set (pc=32'h0000_3020) + we addr 14 din=32'h0000_5557 -> epc=32'h0000_3020. Separately, we addr 14 din=32'h0000_5557 alone -> epc=32'h0000_5554.
- Assert rst while EXL=1 and EPC nonzero, with exl_set also high -> all fields 0, intreq=0, epc=0 next cycle.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - MIPS coprocessor-0 interrupt/exception state and mfc0/mtc0 access
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   pc            : resume address captured into EPC on exception entry
//   addr, din, we : mfc0/mtc0 register number, write data, write strobe
//   exl_set       : exception-entry strobe (sets EXL, captures EPC)
//   exl_clr       : eret strobe (clears EXL)
//   hwint         : level-sensitive hardware interrupt lines
//   intreq        : interrupt pending, enabled and not masked by EXL
//   epc           : current EPC for the next-PC selector
//   dout          : mfc0 read data
module cp0_exception_unit #(
    parameter logic [31:0] PRID_VAL = 32'h0000_3130,
    parameter int          IRQ_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic [4:0]       addr,
    input  logic [31:0]      din,
    input  logic             we,
    input  logic             exl_set,
    input  logic             exl_clr,
    input  logic [IRQ_W-1:0] hwint,
    output logic             intreq,
    output logic [31:0]      epc,
    output logic [31:0]      dout
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [IRQ_W-1:0] im;
    logic [IRQ_W-1:0] ip;
    logic             exl;
    logic             ie;
    logic [4:0]       exc_code;
    logic [31:0]      epc_q;

    logic             sr_we;
    logic             epc_we;
    logic [31:0]      pc_word;
    logic [31:0]      din_word;

    assign sr_we  = we && (addr == REG_SR);
    assign epc_we = we && (addr == REG_EPC);

    // EPC always holds a word-aligned address, whichever source wrote it.
    assign pc_word  = pc & WORD_MASK;
    assign din_word = din & WORD_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            exc_code <= 5'd0;
            epc_q    <= 32'h0;
        end else begin
            // IP is a pure sample of the lines; software cannot write it.
            ip <= hwint;

            if (sr_we) begin
                im <= din[10 +: IRQ_W];
                ie <= din[0];
            end

            // Exception entry wins over an SR write, which wins over eret.
            if (exl_set) begin
                exl <= 1'b1;
            end else if (sr_we) begin
                exl <= din[1];
            end else if (exl_clr) begin
                exl <= 1'b0;
            end

            // Exception entry wins over an mtc0 to EPC in the same cycle.
            if (exl_set) begin
                epc_q    <= pc_word;
                exc_code <= 5'd0;
            end else if (epc_we) begin
                epc_q <= din_word;
            end
        end
    end

    assign intreq = (|(ip & im)) & ie & ~exl;
    assign epc    = epc_q;

    always_comb begin
        dout = 32'h0;
        case (addr)
            REG_SR: begin
                dout[10 +: IRQ_W] = im;
                dout[1]           = exl;
                dout[0]           = ie;
            end
            REG_CAUSE: begin
                dout[10 +: IRQ_W] = ip;
                dout[6:2]         = exc_code;
            end
            REG_EPC:  dout = epc_q;
            REG_PRID: dout = PRID_VAL;
            default:  dout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - scoreboard testbench for cp0_exception_unit
module tb_cp0_exception_unit;

    localparam int K_INTREQ = 0;
    localparam int K_EPC    = 1;
    localparam int K_DOUT   = 2;

    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        we;
    logic        exl_set;
    logic        exl_clr;
    logic [5:0]  hwint;
    logic        intreq;
    logic [31:0] epc;
    logic [31:0] dout;

    sb_entry_t sb_q[$];
    int        n_tests;
    int        n_fail;

    cp0_exception_unit #(
        .PRID_VAL(32'h0000_3130),
        .IRQ_W   (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pc     (pc),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .exl_set(exl_set),
        .exl_clr(exl_clr),
        .hwint  (hwint),
        .intreq (intreq),
        .epc    (epc),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [4:0] ra,
                              input logic [31:0] exp);
        sb_entry_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.raddr = ra;
        e.exp   = exp;
        sb_q.push_back(e);
    endtask

    // Advance one clock edge, drop the one-cycle strobes, then compare every
    // queued expectation against the post-edge state.
    task automatic step();
        sb_entry_t e;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        we      = 1'b0;
        exl_set = 1'b0;
        exl_clr = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_INTREQ: check(e.tag, {31'h0, intreq}, e.exp);
                K_EPC:    check(e.tag, epc, e.exp);
                default: begin
                    addr = e.raddr;
                    #1;
                    check(e.tag, dout, e.exp);
                end
            endcase
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pc      = 32'h0;
        addr    = 5'd0;
        din     = 32'h0;
        we      = 1'b0;
        exl_set = 1'b0;
        exl_clr = 1'b0;

        // Reset with every interrupt line high: all state clear.
        rst   = 1'b1;
        hwint = 6'h3f;
        expect_val("rst_sr",     K_DOUT,   5'd12, 32'h0);
        expect_val("rst_cause",  K_DOUT,   5'd13, 32'h0);
        expect_val("rst_epc_rd", K_DOUT,   5'd14, 32'h0);
        expect_val("rst_prid",   K_DOUT,   5'd15, 32'h0000_3130);
        expect_val("rst_intreq", K_INTREQ, 5'd0,  32'h0);
        expect_val("rst_epc",    K_EPC,    5'd0,  32'h0);
        step();

        // Enable IM[0] and IE with no interrupts pending.
        hwint = 6'h00;
        mtc0(5'd12, 32'h0000_0401);
        expect_val("sr_write",   K_DOUT,   5'd12, 32'h0000_0401);
        expect_val("idle_intrq", K_INTREQ, 5'd0,  32'h0);
        step();

        // hwint[0] raised: IP[10] and intreq one cycle later.
        hwint = 6'h01;
        expect_val("irq0_intreq", K_INTREQ, 5'd0,  32'h1);
        expect_val("irq0_cause",  K_DOUT,   5'd13, 32'h0000_0400);
        step();

        // hwint[1] alone is masked.
        hwint = 6'h02;
        expect_val("irq1_masked", K_INTREQ, 5'd0,  32'h0);
        expect_val("irq1_cause",  K_DOUT,   5'd13, 32'h0000_0800);
        step();

        hwint = 6'h01;
        expect_val("irq0_again", K_INTREQ, 5'd0, 32'h1);
        step();

        // Exception entry: EPC captures pc, EXL set, intreq drops.
        pc      = 32'h0000_3010;
        exl_set = 1'b1;
        expect_val("entry_epc",    K_EPC,    5'd0,  32'h0000_3010);
        expect_val("entry_sr",     K_DOUT,   5'd12, 32'h0000_0403);
        expect_val("entry_intreq", K_INTREQ, 5'd0,  32'h0);
        expect_val("entry_exc",    K_DOUT,   5'd13, 32'h0000_0400);
        step();

        expect_val("nest_blocked", K_INTREQ, 5'd0, 32'h0);
        step();

        // eret with hwint still high.
        exl_clr = 1'b1;
        expect_val("eret_sr",     K_DOUT,   5'd12, 32'h0000_0401);
        expect_val("eret_intreq", K_INTREQ, 5'd0,  32'h1);
        expect_val("eret_epc",    K_EPC,    5'd0,  32'h0000_3010);
        step();

        // exl_set beats an mtc0 to EPC in the same cycle.
        pc      = 32'h0000_3020;
        exl_set = 1'b1;
        mtc0(5'd14, 32'h0000_5557);
        expect_val("prio_epc",    K_EPC,  5'd0,  32'h0000_3020);
        expect_val("prio_epc_rd", K_DOUT, 5'd14, 32'h0000_3020);
        expect_val("prio_sr",     K_DOUT, 5'd12, 32'h0000_0403);
        step();

        // mtc0 to EPC alone: low two bits dropped.
        mtc0(5'd14, 32'h0000_5557);
        expect_val("mtc0_epc",   K_EPC,    5'd0,  32'h0000_5554);
        expect_val("mtc0_intrq", K_INTREQ, 5'd0,  32'h0);
        step();

        exl_clr = 1'b1;
        expect_val("clr_sr", K_DOUT, 5'd12, 32'h0000_0401);
        step();

        // exl_set together with exl_clr keeps EXL set.
        exl_set = 1'b1;
        exl_clr = 1'b1;
        expect_val("set_clr_sr", K_DOUT, 5'd12, 32'h0000_0403);
        step();

        // SR write with din[1]=1 overrides a simultaneous eret.
        exl_clr = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        expect_val("we_clr_sr", K_DOUT, 5'd12, 32'h0000_0403);
        step();

        // SR write with din[1]=0 clears EXL and reopens interrupts.
        mtc0(5'd12, 32'h0000_0401);
        expect_val("sr_clr_exl", K_INTREQ, 5'd0, 32'h1);
        step();

        // exl_set with SR write: IM/IE from din, EXL forced to 1.
        pc      = 32'h0000_3040;
        exl_set = 1'b1;
        mtc0(5'd12, 32'h0000_0000);
        expect_val("set_we_sr",  K_DOUT, 5'd12, 32'h0000_0002);
        expect_val("set_we_epc", K_EPC,  5'd0,  32'h0000_3040);
        step();

        // Writes to Cause and unmapped registers are ignored.
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_ro", K_DOUT, 5'd13, 32'h0000_0400);
        step();
        mtc0(5'd5, 32'hFFFF_FFFF);
        expect_val("unmapped", K_DOUT, 5'd5,  32'h0);
        expect_val("prid_ro",  K_DOUT, 5'd15, 32'h0000_3130);
        step();

        // Reset mid-handler with a concurrent exl_set.
        hwint   = 6'h3f;
        pc      = 32'h0000_3050;
        rst     = 1'b1;
        exl_set = 1'b1;
        expect_val("rst2_sr",     K_DOUT,   5'd12, 32'h0);
        expect_val("rst2_cause",  K_DOUT,   5'd13, 32'h0);
        expect_val("rst2_epc",    K_EPC,    5'd0,  32'h0);
        expect_val("rst2_intreq", K_INTREQ, 5'd0,  32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
